// File: rtl/interval_arbiter_pkg.sv
// interval_arb_pkg: shared types, default counter width and round-robin pick for interval_arbiter
package interval_arb_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int CW_DEF = 6;
    // Index of the first set bit above ptr, wrapping; scanning offsets high-to-low lets the nearest one win.
    function automatic int rr_pick(input logic [7:0] req, input int ptr, input int n);
        int idx;
        rr_pick = ptr;
        for (int k = n; k >= 1; k--) begin
            idx = (ptr + k) % n;
            if (req[idx[2:0]]) rr_pick = idx;
        end
    endfunction
endpackage

// File: rtl/interval_arbiter_if.sv
// interval_arbiter_if: requester/arbiter bundle
//   req, len        : client -> arbiter (level request, per-requester length field)
//   grant, done     : arbiter -> client (one-hot owner, one-cycle completion pulse)
//   busy, count     : arbiter -> client (window active, current counter value)
interface interval_arbiter_if import interval_arb_pkg::*; #(parameter int N_REQ = 4, parameter int CW = CW_DEF);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*CW-1:0] len;
    logic [N_REQ-1:0]    grant;
    logic [N_REQ-1:0]    done;
    logic                busy;
    logic [CW-1:0]       count;
    modport master (output req, len, input grant, done, busy, count);
    modport slave  (input req, len, output grant, done, busy, count);
endinterface

// File: rtl/interval_arbiter_counter.sv
// interval_counter: CW-bit synchronous up-counter with clear, enable and terminal match
//   clk, reset : clock, synchronous active-high reset
//   clr, en    : synchronous clear (wins over enable), count enable
//   limit      : terminal value; match is high while count == limit
//   count      : current value
module interval_counter #(parameter int CW = 6) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] limit,
    output logic [CW-1:0] count,
    output logic          match
);
    always_ff @(posedge clk)
        if (reset || clr) count <= '0;
        else if (en)      count <= count + 1'b1;
    assign match = count == limit;
endmodule

// File: rtl/interval_arbiter.sv
// interval_arbiter: round-robin sharing of one interval counter among N_REQ requesters
//   clk, reset : clock, synchronous active-high reset
//   bus        : interval_arbiter_if.slave (req, len in; grant, done, busy, count out)
//   INTERVAL_ARB_ABORT_EN : when defined, the owner dropping req during RUN aborts the window
module interval_arbiter import interval_arb_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int CW    = CW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    interval_arbiter_if.slave bus
);
    localparam int PW = $clog2(N_REQ);
    state_t        state, state_n;
    logic [PW-1:0] owner, owner_n, ptr, ptr_n;
    logic [CW-1:0] len_q, len_n;
    logic          clr, en, match;
    int            pick;

    interval_counter #(.CW(CW)) u_cnt (
        .clk(clk), .reset(reset), .clr(clr), .en(en),
        .limit(len_q), .count(bus.count), .match(match)
    );

    assign pick      = rr_pick(8'(bus.req), int'(ptr), N_REQ);
    assign bus.busy  = state != IDLE;
    assign bus.grant = bus.busy ? N_REQ'(1) << owner : '0;
    assign bus.done  = state == DONE ? bus.grant : '0;

    always_ff @(posedge clk)
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= PW'(N_REQ - 1);
            len_q <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            ptr   <= ptr_n;
            len_q <= len_n;
        end

    // The counter is held clear in IDLE and cleared on every exit from a window,
    // so it already reads 0 on the first RUN cycle.
    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        len_n   = len_q;
        clr     = 1'b0;
        en      = 1'b0;
        case (state)
            IDLE: begin
                clr = 1'b1;
                if (|bus.req) begin
                    state_n = RUN;
                    owner_n = PW'(pick);
                    len_n   = bus.len[owner_n*CW +: CW];
                end
            end
            RUN: begin
`ifdef INTERVAL_ARB_ABORT_EN
                if (!bus.req[owner]) begin
                    state_n = IDLE;
                    ptr_n   = owner;
                    clr     = 1'b1;
                end else if (match) state_n = DONE;
                else en = 1'b1;
`else
                if (match) state_n = DONE;
                else en = 1'b1;
`endif
            end
            DONE: begin
                state_n = IDLE;
                ptr_n   = owner;
                clr     = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
